// File: rtl/intr_entry_seq.sv
// Interrupt entry / rfi return sequencer: saves PC/MSR to SRR0/SRR1, masks MSR and
// redirects fetch to the vector, or restores MSR from SRR1 and jumps to SRR0 on rfi.
module intr_entry_seq #(
  parameter int               EXC_W        = 4,
  parameter logic [9:0]       SRR0_ADDR    = 10'd26,
  parameter logic [9:0]       SRR1_ADDR    = 10'd27,
  parameter logic [31:0]      MSR_CLR_MASK = 32'hFFFF_3FCF,
  parameter logic [EXC_W-1:0] PROG_CODE    = EXC_W'(6)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [EXC_W-1:0] excepCode,
  input  logic [31:0]      intrEntryAddr,
  input  logic [2:0]       progErrCode,
  input  logic [31:0]      pc_cur,
  input  logic [31:0]      MSR,
  input  logic             rfi_req,
  input  logic [31:0]      spr_rd,
  output logic [9:0]       spr_addr,
  output logic [31:0]      spr_wd,
  output logic             spr_wr,
  output logic             msr_wr,
  output logic [31:0]      msr_wd,
  output logic             flush,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             ack,
  output logic             rfi_done,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, FLUSH, SAVE0, SAVE1, SETMSR, VECT, DONE,
    RFI0, RFI1, RFI_MSR, RFI_JMP
  } state_t;

  state_t           state, state_next;
  logic [EXC_W-1:0] code_lat;
  logic [31:0]      entry_lat, pc_lat, msr_lat, srr0_lat, srr1_lat;
  logic [2:0]       perr_lat;
  logic [31:0]      srr1_save;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      code_lat  <= '0;
      entry_lat <= '0;
      pc_lat    <= '0;
      msr_lat   <= '0;
      perr_lat  <= '0;
      srr0_lat  <= '0;
      srr1_lat  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && excepCode != '0) begin
        code_lat  <= excepCode;
        entry_lat <= intrEntryAddr;
        pc_lat    <= pc_cur;
        msr_lat   <= MSR;
        perr_lat  <= progErrCode;
      end
      if (state == RFI0) srr0_lat <= spr_rd;
      if (state == RFI1) srr1_lat <= spr_rd;
    end
  end

  // MSR bits 11..13 in big-endian [0:31] numbering sit at little-endian indices 20..18.
  always_comb begin
    srr1_save = msr_lat;
    if (code_lat == PROG_CODE) srr1_save[20:18] = perr_lat;
  end

  always_comb begin
    state_next  = state;
    spr_addr    = '0;
    spr_wd      = '0;
    spr_wr      = 1'b0;
    msr_wr      = 1'b0;
    msr_wd      = '0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    ack         = 1'b0;
    rfi_done    = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (excepCode != '0) state_next = FLUSH;
        else if (rfi_req)    state_next = RFI0;
      end
      FLUSH: begin
        flush      = 1'b1;
        state_next = SAVE0;
      end
      SAVE0: begin
        spr_wr     = 1'b1;
        spr_addr   = SRR0_ADDR;
        spr_wd     = pc_lat;
        state_next = SAVE1;
      end
      SAVE1: begin
        spr_wr     = 1'b1;
        spr_addr   = SRR1_ADDR;
        spr_wd     = srr1_save;
        state_next = SETMSR;
      end
      SETMSR: begin
        msr_wr     = 1'b1;
        msr_wd     = msr_lat & MSR_CLR_MASK;
        state_next = VECT;
      end
      VECT: begin
        pc_redirect = 1'b1;
        pc_target   = entry_lat;
        ack         = 1'b1;
        state_next  = DONE;
      end
      DONE: state_next = IDLE;
      RFI0: begin
        spr_addr   = SRR0_ADDR;
        state_next = RFI1;
      end
      RFI1: begin
        spr_addr   = SRR1_ADDR;
        state_next = RFI_MSR;
      end
      RFI_MSR: begin
        msr_wr     = 1'b1;
        msr_wd     = srr1_lat;
        state_next = RFI_JMP;
      end
      RFI_JMP: begin
        pc_redirect = 1'b1;
        pc_target   = srr0_lat;
        rfi_done    = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_intr_entry_seq.sv
// Bench for intr_entry_seq: directed and random exception/rfi sequences checked against
// an event-level reference model and a behavioural SPR file.
module tb_intr_entry_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  excepCode;
  logic [31:0] intrEntryAddr;
  logic [2:0]  progErrCode;
  logic [31:0] pc_cur;
  logic [31:0] MSR;
  logic        rfi_req;
  logic [31:0] spr_rd;
  logic [9:0]  spr_addr;
  logic [31:0] spr_wd;
  logic        spr_wr;
  logic        msr_wr;
  logic [31:0] msr_wd;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        ack;
  logic        rfi_done;
  logic        busy;

  intr_entry_seq dut (
    .clk(clk), .rst(rst), .excepCode(excepCode), .intrEntryAddr(intrEntryAddr),
    .progErrCode(progErrCode), .pc_cur(pc_cur), .MSR(MSR), .rfi_req(rfi_req),
    .spr_rd(spr_rd), .spr_addr(spr_addr), .spr_wd(spr_wd), .spr_wr(spr_wr),
    .msr_wr(msr_wr), .msr_wd(msr_wd), .flush(flush), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .ack(ack), .rfi_done(rfi_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural SPR file the sequencer reads and writes.
  logic [31:0] spr_file [0:1023];
  assign spr_rd = spr_file[spr_addr];
  always @(posedge clk) if (spr_wr) spr_file[spr_addr] <= spr_wd;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed events of one sequence
  int          busy_cyc, n_flush, flush_cyc, n_spr, n_msr, n_redir, n_ack, n_rfi;
  int          n_dual, n_ack_redir, n_rfi_redir, finished;
  logic [9:0]  spr_a [0:3];
  logic [31:0] spr_d [0:3];
  logic [31:0] msr_val, redir_tgt;

  // Reference model of the architected SRR contents
  logic [31:0] m_srr0, m_srr1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe from the next edge until busy drops, with optional injected events.
  task automatic run_observe(input int inject_at, input logic [3:0] inj_code, input int rst_at);
    busy_cyc = 0; n_flush = 0; flush_cyc = 0; n_spr = 0; n_msr = 0; n_redir = 0;
    n_ack = 0; n_rfi = 0; n_dual = 0; n_ack_redir = 0; n_rfi_redir = 0; finished = 0;
    msr_val = '0; redir_tgt = '0;
    for (int i = 0; i < 4; i++) begin spr_a[i] = '0; spr_d[i] = '0; end
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) rfi_req = 1'b0;
      if (!busy) begin finished = 1; break; end
      busy_cyc++;
      if (flush) begin n_flush++; if (flush_cyc == 0) flush_cyc = c; end
      if (spr_wr) begin
        if (n_spr < 4) begin spr_a[n_spr] = spr_addr; spr_d[n_spr] = spr_wd; end
        n_spr++;
      end
      if (msr_wr) begin n_msr++; msr_val = msr_wd; end
      if (spr_wr && msr_wr) n_dual++;
      if (pc_redirect) begin n_redir++; redir_tgt = pc_target; end
      if (ack) begin n_ack++; excepCode = 4'd0; end
      if (ack && pc_redirect) n_ack_redir++;
      if (rfi_done) n_rfi++;
      if (rfi_done && pc_redirect) n_rfi_redir++;
      if (c == inject_at) excepCode = inj_code;
      if (c == rst_at) begin rst = 1'b0; excepCode = 4'd0; end
    end
  endtask

  function automatic logic [31:0] model_srr1(input logic [3:0] code, input logic [31:0] msr,
                                             input logic [2:0] perr);
    if (code == 4'd6) return (msr & 32'hFFE3_FFFF) | (32'(perr) << 18);
    return msr;
  endfunction

  task automatic expect_exc(input string tag, input logic [3:0] code, input logic [31:0] entry,
                            input logic [31:0] pc, input logic [31:0] msr, input logic [2:0] perr);
    m_srr0 = pc;
    m_srr1 = model_srr1(code, msr, perr);
    check({tag, ".done"},      32'(finished),    32'd1);
    check({tag, ".busy_cyc"},  32'(busy_cyc),    32'd6);
    check({tag, ".flush_cyc"}, 32'(flush_cyc),   32'd1);
    check({tag, ".n_flush"},   32'(n_flush),     32'd1);
    check({tag, ".n_spr"},     32'(n_spr),       32'd2);
    check({tag, ".srr0_a"},    32'(spr_a[0]),    32'd26);
    check({tag, ".srr0_d"},    spr_d[0],         m_srr0);
    check({tag, ".srr1_a"},    32'(spr_a[1]),    32'd27);
    check({tag, ".srr1_d"},    spr_d[1],         m_srr1);
    check({tag, ".n_msr"},     32'(n_msr),       32'd1);
    check({tag, ".msr_wd"},    msr_val,          msr & 32'hFFFF_3FCF);
    check({tag, ".n_redir"},   32'(n_redir),     32'd1);
    check({tag, ".target"},    redir_tgt,        entry);
    check({tag, ".ack_redir"}, 32'(n_ack_redir), 32'd1);
    check({tag, ".n_ack"},     32'(n_ack),       32'd1);
    check({tag, ".n_rfi"},     32'(n_rfi),       32'd0);
    check({tag, ".dual"},      32'(n_dual),      32'd0);
  endtask

  task automatic expect_rfi(input string tag);
    check({tag, ".done"},      32'(finished),    32'd1);
    check({tag, ".busy_cyc"},  32'(busy_cyc),    32'd4);
    check({tag, ".n_spr"},     32'(n_spr),       32'd0);
    check({tag, ".n_msr"},     32'(n_msr),       32'd1);
    check({tag, ".msr_wd"},    msr_val,          m_srr1);
    check({tag, ".n_redir"},   32'(n_redir),     32'd1);
    check({tag, ".target"},    redir_tgt,        m_srr0);
    check({tag, ".rfi_redir"}, 32'(n_rfi_redir), 32'd1);
    check({tag, ".n_ack"},     32'(n_ack),       32'd0);
    check({tag, ".n_flush"},   32'(n_flush),     32'd0);
  endtask

  task automatic drive_exc(input logic [3:0] code, input logic [31:0] entry, input logic [31:0] pc,
                           input logic [31:0] msr, input logic [2:0] perr);
    intrEntryAddr = entry;
    pc_cur        = pc;
    MSR           = msr;
    progErrCode   = perr;
    excepCode     = code;
  endtask

  initial begin
    logic [3:0]  r_code;
    logic [31:0] r_entry, r_pc, r_msr;
    logic [2:0]  r_perr;

    rst = 1'b0; rfi_req = 1'b0;
    drive_exc(4'd3, 32'h0000_0300, 32'h0000_0100, 32'h0000_FFFF, 3'd0);
    tick(); tick();
    check("rst.busy",     32'(busy),        32'd0);
    check("rst.flush",    32'(flush),       32'd0);
    check("rst.spr_wr",   32'(spr_wr),      32'd0);
    check("rst.msr_wr",   32'(msr_wr),      32'd0);
    check("rst.redirect", 32'(pc_redirect), 32'd0);
    check("rst.ack",      32'(ack),         32'd0);
    check("rst.rfi_done", 32'(rfi_done),    32'd0);
    check("rst.spr_addr", 32'(spr_addr),    32'd0);
    check("rst.spr_wd",   spr_wd,           32'd0);
    check("rst.msr_wd",   msr_wd,           32'd0);
    check("rst.target",   pc_target,        32'd0);
    rst = 1'b1;
    run_observe(0, 4'd0, 0);
    expect_exc("rst_exc", 4'd3, 32'h0000_0300, 32'h0000_0100, 32'h0000_FFFF, 3'd0);

    drive_exc(4'd2, 32'h0000_0700, 32'h0000_1234, 32'h0000_C032, 3'd0);
    run_observe(0, 4'd0, 0);
    expect_exc("entry", 4'd2, 32'h0000_0700, 32'h0000_1234, 32'h0000_C032, 3'd0);
    check("entry.msr_const", msr_val, 32'h0000_0002);

    drive_exc(4'd6, 32'h0000_0700, 32'h0000_2000, 32'h0000_0000, 3'b101);
    run_observe(0, 4'd0, 0);
    expect_exc("prog", 4'd6, 32'h0000_0700, 32'h0000_2000, 32'h0000_0000, 3'b101);
    check("prog.srr1_const", spr_d[1], 32'h0014_0000);

    drive_exc(4'd2, 32'h0000_0700, 32'h0000_1238, 32'h0000_8000, 3'd0);
    run_observe(0, 4'd0, 0);
    expect_exc("preload", 4'd2, 32'h0000_0700, 32'h0000_1238, 32'h0000_8000, 3'd0);
    rfi_req = 1'b1;
    run_observe(0, 4'd0, 0);
    expect_rfi("rfi");
    check("rfi.msr_const",    msr_val,   32'h0000_8000);
    check("rfi.target_const", redir_tgt, 32'h0000_1238);

    drive_exc(4'd1, 32'h0000_0100, 32'h0000_4444, 32'h0000_9030, 3'd0);
    rfi_req = 1'b1;
    run_observe(0, 4'd0, 0);
    expect_exc("collide", 4'd1, 32'h0000_0100, 32'h0000_4444, 32'h0000_9030, 3'd0);

    // rfi with an exception arriving during RFI1; the exception follows immediately.
    drive_exc(4'd0, 32'h0000_0500, 32'h0000_5550, 32'h0000_00F0, 3'd0);
    rfi_req = 1'b1;
    run_observe(2, 4'd4, 0);
    expect_rfi("late_rfi");
    run_observe(0, 4'd0, 0);
    expect_exc("late_exc", 4'd4, 32'h0000_0500, 32'h0000_5550, 32'h0000_00F0, 3'd0);

    drive_exc(4'd5, 32'h0000_0900, 32'h0000_6660, 32'h0000_FFFF, 3'd0);
    run_observe(0, 4'd0, 3);
    check("midrst.done",     32'(finished), 32'd1);
    check("midrst.busy_cyc", 32'(busy_cyc), 32'd3);
    check("midrst.n_spr",    32'(n_spr),    32'd2);
    check("midrst.n_msr",    32'(n_msr),    32'd0);
    check("midrst.n_ack",    32'(n_ack),    32'd0);
    check("midrst.n_redir",  32'(n_redir),  32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst.idle", 32'(busy), 32'd0);

    for (int k = 0; k < 8; k++) begin
      r_code  = 4'($urandom_range(15, 1));
      if (k[0]) r_code = 4'd6;
      r_entry = $urandom;
      r_pc    = $urandom;
      r_msr   = $urandom;
      r_perr  = 3'($urandom_range(7, 0));
      drive_exc(r_code, r_entry, r_pc, r_msr, r_perr);
      run_observe(0, 4'd0, 0);
      expect_exc("rnd_exc", r_code, r_entry, r_pc, r_msr, r_perr);
      rfi_req = 1'b1;
      run_observe(0, 4'd0, 0);
      expect_rfi("rnd_rfi");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
